// File: rtl/wvb_reader.sv
// Waveform buffer read engine: pops a header, streams start..stop (wrapping) with SOP/EOP, pulses rddone.
// First word 2 cycles after entering STREAM; 2-entry skid plus credit-limited read-ahead absorbs dout_ready stalls.
module wvb_reader #(
  parameter int P_ADR_WIDTH  = 12,
  parameter int P_DATA_WIDTH = 22,
  parameter int P_HDR_WIDTH  = 80
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [P_HDR_WIDTH-1:0]  hdr_data,
  input  logic                    hdr_empty,
  output logic                    hdr_rdreq,
  output logic [P_ADR_WIDTH-1:0]  wvb_rd_addr,
  output logic                    wvb_rd_en,
  input  logic [P_DATA_WIDTH-1:0] wvb_rd_data,
  output logic                    wvb_rddone,
  output logic [47:0]             evt_ltc,
  output logic [1:0]              evt_trig_src,
  output logic                    evt_cnst_run,
  output logic [4:0]              evt_pre_conf,
  output logic [P_ADR_WIDTH:0]    evt_n_words,
  output logic [P_DATA_WIDTH-1:0] dout,
  output logic                    dout_valid,
  input  logic                    dout_ready,
  output logic                    dout_sop,
  output logic                    dout_eop,
  output logic                    busy
);
  localparam int A         = P_ADR_WIDTH;
  // Header word layout, LSB first: pre_conf[4:0], cnst_run, trig_src[1:0], stop, start, ltc[47:0].
  localparam int OFS_STOP  = 8;
  localparam int OFS_START = 8 + A;
  localparam int OFS_LTC   = 8 + 2 * A;

  typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

  state_t                  state;
  logic [A-1:0]            rd_ptr;
  logic [A-1:0]            stop_addr;
  logic                    issue_done;
  logic                    first_issue;
  logic                    inf_vld;
  logic                    inf_sop;
  logic                    inf_eop;
  logic [1:0]              sk_cnt;
  logic [P_DATA_WIDTH-1:0] sk1_dat;
  logic                    sk1_sop;
  logic                    sk1_eop;
  logic [A-1:0]            hdr_start;
  logic [A-1:0]            hdr_stop;
  logic                    pop;
  logic [2:0]              occ;

  assign hdr_start = hdr_data[OFS_START +: A];
  assign hdr_stop  = hdr_data[OFS_STOP +: A];

  assign dout_valid  = (sk_cnt != 2'd0);
  assign pop         = dout_valid & dout_ready;
  // Occupancy after this cycle's departure; pop implies sk_cnt >= 1, so no underflow.
  assign occ         = {1'b0, sk_cnt} + {2'b00, inf_vld} - {2'b00, pop};
  assign hdr_rdreq   = !rst && (state == S_IDLE) && !hdr_empty;
  assign wvb_rd_en   = !rst && (state == S_STREAM) && !issue_done && (occ < 3'd2);
  assign wvb_rd_addr = rd_ptr;
  assign wvb_rddone  = (state == S_DONE);
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      rd_ptr       <= '0;
      stop_addr    <= '0;
      issue_done   <= 1'b0;
      first_issue  <= 1'b0;
      inf_vld      <= 1'b0;
      inf_sop      <= 1'b0;
      inf_eop      <= 1'b0;
      sk_cnt       <= 2'd0;
      sk1_dat      <= '0;
      sk1_sop      <= 1'b0;
      sk1_eop      <= 1'b0;
      dout         <= '0;
      dout_sop     <= 1'b0;
      dout_eop     <= 1'b0;
      evt_ltc      <= '0;
      evt_trig_src <= '0;
      evt_cnst_run <= 1'b0;
      evt_pre_conf <= '0;
      evt_n_words  <= '0;
    end else begin
      // Tags travel with the read so the word lands in the skid already marked.
      inf_vld <= wvb_rd_en;
      inf_sop <= first_issue;
      inf_eop <= (rd_ptr == stop_addr);

      if (wvb_rd_en) begin
        rd_ptr      <= rd_ptr + 1'b1;
        first_issue <= 1'b0;
        if (rd_ptr == stop_addr) issue_done <= 1'b1;
      end

      case ({inf_vld, pop})
        2'b10: begin
          if (sk_cnt == 2'd0) begin
            dout     <= wvb_rd_data;
            dout_sop <= inf_sop;
            dout_eop <= inf_eop;
          end else begin
            sk1_dat <= wvb_rd_data;
            sk1_sop <= inf_sop;
            sk1_eop <= inf_eop;
          end
          sk_cnt <= sk_cnt + 2'd1;
        end
        2'b01: begin
          dout     <= sk1_dat;
          dout_sop <= sk1_sop;
          dout_eop <= sk1_eop;
          sk_cnt   <= sk_cnt - 2'd1;
        end
        2'b11: begin
          if (sk_cnt == 2'd1) begin
            dout     <= wvb_rd_data;
            dout_sop <= inf_sop;
            dout_eop <= inf_eop;
          end else begin
            dout     <= sk1_dat;
            dout_sop <= sk1_sop;
            dout_eop <= sk1_eop;
            sk1_dat  <= wvb_rd_data;
            sk1_sop  <= inf_sop;
            sk1_eop  <= inf_eop;
          end
        end
        default: ;
      endcase

      case (state)
        S_IDLE: begin
          if (!hdr_empty) begin
            rd_ptr       <= hdr_start;
            stop_addr    <= hdr_stop;
            issue_done   <= 1'b0;
            first_issue  <= 1'b1;
            evt_ltc      <= hdr_data[OFS_LTC +: 48];
            evt_trig_src <= hdr_data[7:6];
            evt_cnst_run <= hdr_data[5];
            evt_pre_conf <= hdr_data[4:0];
            evt_n_words  <= {1'b0, hdr_stop - hdr_start} + {{A{1'b0}}, 1'b1};
            state        <= S_STREAM;
          end
        end
        S_STREAM: if (pop && dout_eop) state <= S_DONE;
        S_DONE:   state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wvb_reader.sv
// Randomized bench for wvb_reader: header FIFO and RAM models, word-level scoreboard checked by a negedge monitor.
module tb_wvb_reader;
  localparam int A = 12;
  localparam int D = 22;
  localparam int H = 80;
  localparam int DEPTH = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [H-1:0] hdr_data = '0;
  logic         hdr_empty = 1'b1;
  logic         hdr_rdreq;
  logic [A-1:0] wvb_rd_addr;
  logic         wvb_rd_en;
  logic [D-1:0] wvb_rd_data = '0;
  logic         wvb_rddone;
  logic [47:0]  evt_ltc;
  logic [1:0]   evt_trig_src;
  logic         evt_cnst_run;
  logic [4:0]   evt_pre_conf;
  logic [A:0]   evt_n_words;
  logic [D-1:0] dout;
  logic         dout_valid;
  logic         dout_ready = 1'b0;
  logic         dout_sop;
  logic         dout_eop;
  logic         busy;

  always #5 clk = ~clk;

  wvb_reader #(.P_ADR_WIDTH(A), .P_DATA_WIDTH(D), .P_HDR_WIDTH(H)) dut (
    .clk(clk), .rst(rst), .hdr_data(hdr_data), .hdr_empty(hdr_empty), .hdr_rdreq(hdr_rdreq),
    .wvb_rd_addr(wvb_rd_addr), .wvb_rd_en(wvb_rd_en), .wvb_rd_data(wvb_rd_data),
    .wvb_rddone(wvb_rddone), .evt_ltc(evt_ltc), .evt_trig_src(evt_trig_src),
    .evt_cnst_run(evt_cnst_run), .evt_pre_conf(evt_pre_conf), .evt_n_words(evt_n_words),
    .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_sop(dout_sop),
    .dout_eop(dout_eop), .busy(busy)
  );

  typedef struct {
    logic [D-1:0] dat;
    logic         sop;
    logic         eop;
    logic [A:0]   nw;
    logic [47:0]  ltc;
    logic [1:0]   trig;
    logic         cnst;
    logic [4:0]   pre;
  } exp_t;

  logic [D-1:0] mem [DEPTH];
  exp_t         exp_q[$];
  logic [H-1:0] hq[$];
  int           checks = 0, passed = 0;
  int           cyc = 0, rq_cyc = 0, eop_cyc = 0;
  int           rdreq_cnt = 0, done_cnt = 0, acc_cnt = 0, pushes = 0, aborted = 0;
  bit           have_eop = 0, eop_pend = 0, prev_stall = 0, lat_chk = 0;
  logic [D+1:0] prev_word;
  int           rmode = 0;
  exp_t         me;

  task automatic chk_eq(input string nm, input logic [95:0] act, input logic [95:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, req);
  endtask

  task automatic chk_b(input string nm, input bit ok);
    checks++;
    if (ok) passed++;
    else $display("FAIL %s: condition false at cycle %0d", nm, cyc);
  endtask

  task automatic upd_fifo();
    hdr_empty = (hq.size() == 0);
    hdr_data  = hdr_empty ? '0 : hq[0];
  endtask

  // Reference model: an event is simply the words at start, start+1, ... (mod depth), n of them.
  task automatic push_evt(input logic [A-1:0] s, input logic [A-1:0] e);
    exp_t         x;
    logic [47:0]  ltc;
    logic [1:0]   trig;
    logic         cnst;
    logic [4:0]   pre;
    int           n;
    ltc  = 48'({$urandom, $urandom});
    trig = 2'($urandom);
    cnst = 1'($urandom);
    pre  = 5'($urandom);
    n    = ((int'(e) - int'(s) + DEPTH) % DEPTH) + 1;
    hq.push_back({ltc, s, e, trig, cnst, pre});
    upd_fifo();
    pushes++;
    for (int i = 0; i < n; i++) begin
      x.dat  = mem[(int'(s) + i) % DEPTH];
      x.sop  = (i == 0);
      x.eop  = (i == n - 1);
      x.nw   = 13'(n);
      x.ltc  = ltc;
      x.trig = trig;
      x.cnst = cnst;
      x.pre  = pre;
      exp_q.push_back(x);
    end
  endtask

  task automatic wait_idle(input int budget, input string nm);
    bit done;
    done = 0;
    for (int i = 0; i < budget && !done; i++) begin
      @(posedge clk); #1;
      if (exp_q.size() == 0 && hq.size() == 0 && !busy) done = 1;
    end
    chk_b({nm, "_completes"}, done);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) if (wvb_rd_en) wvb_rd_data <= mem[wvb_rd_addr];

  always @(posedge clk) begin : fifo_model
    bit p;
    p = hdr_rdreq;
    #1;
    if (p && hq.size() > 0) void'(hq.pop_front());
    upd_fifo();
  end

  always @(posedge clk) begin : ready_drv
    #1;
    case (rmode)
      0:       dout_ready = 1'b1;
      1:       dout_ready = ($urandom_range(0, 9) < 3);
      default: dout_ready = 1'b0;
    endcase
  end

  always @(negedge clk) begin : monitor
    if (rst) begin
      prev_stall = 0;
    end else begin
      if (hdr_rdreq) begin
        rdreq_cnt++;
        rq_cyc = cyc;
        if (have_eop) chk_b("rdreq_gap_after_eop", (cyc - eop_cyc) >= 2);
      end
      if (prev_stall) begin
        chk_b("stall_valid_held", dout_valid == 1'b1);
        chk_eq("stall_word_held", 96'({dout_sop, dout_eop, dout}), 96'(prev_word));
      end
      if (dout_valid && dout_ready) begin
        acc_cnt++;
        if (exp_q.size() == 0) begin
          chk_eq("unexpected_word", 96'(dout), 96'(0));
        end else begin
          me = exp_q.pop_front();
          chk_eq("word_sop_eop_dat", 96'({dout_sop, dout_eop, dout}), 96'({me.sop, me.eop, me.dat}));
          chk_eq("evt_fields", 96'({evt_ltc, evt_trig_src, evt_cnst_run, evt_pre_conf, evt_n_words}),
                 96'({me.ltc, me.trig, me.cnst, me.pre, me.nw}));
          if (lat_chk && me.sop) chk_eq("first_word_latency", 96'(cyc - rq_cyc), 96'(3));
          if (lat_chk && me.eop) chk_eq("eop_latency", 96'(cyc - rq_cyc), 96'(int'(me.nw) + 2));
          if (me.eop) begin
            eop_pend = 1;
            eop_cyc  = cyc;
            have_eop = 1;
          end
        end
      end
      if (wvb_rddone) begin
        chk_b("rddone_after_eop", eop_pend);
        chk_eq("rddone_timing", 96'(cyc - eop_cyc), 96'(1));
        eop_pend = 0;
        done_cnt++;
      end
      prev_stall = dout_valid && !dout_ready;
      prev_word  = {dout_sop, dout_eop, dout};
    end
  end

  initial begin
    int s, len, base;
    bit quiet, hit;
    for (int a = 0; a < DEPTH; a++) mem[a] = {10'($urandom), 12'(a)};
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    chk_eq("reset_ctrl", 96'({hdr_rdreq, wvb_rd_en, wvb_rddone, dout_valid, dout_sop, dout_eop, busy}), 96'(0));
    chk_eq("reset_data", 96'({wvb_rd_addr, dout, evt_ltc}), 96'(0));
    rst = 0;

    lat_chk = 1;
    push_evt(12'h010, 12'h013);
    wait_idle(100, "basic");
    push_evt(12'hFFE, 12'h001);
    wait_idle(100, "wrap");
    push_evt(12'h200, 12'h200);
    wait_idle(100, "single");
    push_evt(12'h005, 12'h004);
    wait_idle(5000, "full_buffer");

    lat_chk = 0;
    rmode = 1;
    push_evt(12'h7F0, 12'h82F);
    wait_idle(2000, "backpressure64");

    rmode = 0;
    lat_chk = 1;
    push_evt(12'h100, 12'h104);
    push_evt(12'hFFD, 12'h002);
    push_evt(12'h300, 12'h300);
    wait_idle(300, "back_to_back");
    lat_chk = 0;

    quiet = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (wvb_rd_en || hdr_rdreq || busy) quiet = 0;
    end
    chk_b("idle_when_empty", quiet);

    rmode = 1;
    for (int k = 0; k < 6; k++) begin
      s   = $urandom_range(0, DEPTH - 1);
      len = $urandom_range(1, 40);
      push_evt(12'(s), 12'((s + len - 1) % DEPTH));
      repeat ($urandom_range(0, 5)) @(posedge clk);
      #1;
    end
    wait_idle(3000, "random_events");

    rmode = 0;
    base = acc_cnt;
    push_evt(12'h400, 12'h413);
    hit = 0;
    for (int i = 0; i < 200 && !hit; i++) begin
      @(negedge clk);
      if (acc_cnt >= base + 5) hit = 1;
    end
    chk_b("reset_test_reached_5_words", hit);
    @(posedge clk); #1;
    rst = 1;
    rmode = 2;
    dout_ready = 1'b0;
    aborted++;
    @(posedge clk); #1;
    chk_eq("midrst_ctrl", 96'({hdr_rdreq, wvb_rd_en, wvb_rddone, dout_valid, dout_sop, dout_eop, busy}), 96'(0));
    chk_eq("midrst_data", 96'({wvb_rd_addr, dout, evt_ltc}), 96'(0));
    chk_eq("midrst_evt", 96'({evt_trig_src, evt_cnst_run, evt_pre_conf, evt_n_words}), 96'(0));
    exp_q.delete();
    rst = 0;
    rmode = 0;
    repeat (3) @(posedge clk);
    #1;
    lat_chk = 1;
    push_evt(12'hABC, 12'hAC5);
    wait_idle(200, "after_reset");
    lat_chk = 0;

    repeat (5) @(posedge clk);
    chk_eq("rdreq_count", 96'(rdreq_cnt), 96'(pushes));
    chk_eq("rddone_count", 96'(done_cnt), 96'(pushes - aborted));
    chk_eq("scoreboard_drained", 96'(exp_q.size()), 96'(0));
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
